// File: rtl/avalon_st_pkt_fifo.sv
// Store-and-forward Avalon-ST packet buffer: forwards only complete packets, discards malformed/oversize/overflowing ones whole; counters via AVST_PKT_FIFO_STATS_EN.
// Latency 2 edges from eop acceptance to first output beat; sink never back-pressures, source holds its beat while !src_ready.
module avalon_st_pkt_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int ADDR_WIDTH    = 6,
  parameter int MAX_PKT_WORDS = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    snk_data,
  input  logic                     snk_valid,
  input  logic                     snk_startofpacket,
  input  logic                     snk_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]   snk_empty,
  input  logic [CHANNEL_WIDTH-1:0] snk_channel,
  output logic                     snk_ready,
  output logic [DATA_WIDTH-1:0]    src_data,
  output logic                     src_valid,
  output logic                     src_startofpacket,
  output logic                     src_endofpacket,
  output logic [EMPTY_WIDTH-1:0]   src_empty,
  output logic [CHANNEL_WIDTH-1:0] src_channel,
  input  logic                     src_ready
`ifdef AVST_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]              stat_fwd_pkts,
  output logic [31:0]              stat_drop_pkts,
  output logic [31:0]              stat_orphan_beats
`endif
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0]    dat;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   emp;
    logic [CHANNEL_WIDTH-1:0] ch;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_DROP} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MAX_PKT_WORDS);

  state_t                   r_state;
  logic [ADDR_WIDTH-1:0]    r_wr_ptr, r_commit_ptr, r_rd_ptr, r_len;
  logic [CHANNEL_WIDTH-1:0] r_ch;
  logic                     r_snk_ready, r_src_valid;
  entry_t                   r_src;
  entry_t                   r_mem [2**ADDR_WIDTH];

  logic                  w_acc, w_sop, w_restart, w_sop_ovf, w_beat_ovf, w_write, w_load;
  logic [ADDR_WIDTH-1:0] w_base, w_waddr;
  entry_t                w_wentry, w_rentry;

  assign w_acc     = snk_valid && r_snk_ready;
  assign w_sop     = w_acc && snk_startofpacket;
  assign w_restart = w_sop && (r_state == S_WR);
  // A restarting sop is written where the abandoned partial packet began.
  assign w_base    = w_restart ? r_commit_ptr : r_wr_ptr;
  assign w_sop_ovf = w_sop && ((w_base + 1'b1) == r_rd_ptr);
  assign w_beat_ovf = w_acc && !snk_startofpacket && (r_state == S_WR) &&
                      (((r_wr_ptr + 1'b1) == r_rd_ptr) || (r_len >= MAX_LEN));
  assign w_write  = (w_sop && !w_sop_ovf) ||
                    (w_acc && !snk_startofpacket && (r_state == S_WR) && !w_beat_ovf);
  assign w_waddr  = w_sop ? w_base : r_wr_ptr;
  assign w_wentry = '{dat: snk_data, sop: w_sop, eop: snk_endofpacket, emp: snk_empty,
                      ch: (w_sop ? snk_channel : r_ch)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_len        <= '0;
      r_ch         <= '0;
      r_snk_ready  <= 1'b0;
    end else begin
      r_snk_ready <= 1'b1;
      if (w_sop) begin
        if (w_sop_ovf) begin
          r_wr_ptr <= w_base;
          r_state  <= snk_endofpacket ? S_IDLE : S_DROP;
        end else begin
          r_wr_ptr <= w_base + 1'b1;
          r_len    <= ADDR_WIDTH'(1);
          r_ch     <= snk_channel;
          if (snk_endofpacket) begin
            r_commit_ptr <= w_base + 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_WR;
          end
        end
      end else if (w_acc) begin
        case (r_state)
          S_WR: begin
            if (w_beat_ovf) begin
              r_wr_ptr <= r_commit_ptr;
              r_state  <= snk_endofpacket ? S_IDLE : S_DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_len    <= r_len + 1'b1;
              if (snk_endofpacket) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
                r_state      <= S_IDLE;
              end
            end
          end
          S_DROP: if (snk_endofpacket) r_state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_waddr] <= w_wentry;
  end

  assign w_load   = (r_rd_ptr != r_commit_ptr) && (!r_src_valid || src_ready);
  assign w_rentry = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_src_valid <= 1'b0;
      r_src       <= '0;
    end else if (w_load) begin
      r_src <= w_rentry;
      if (!w_rentry.eop) r_src.emp <= '0;
      r_src_valid <= 1'b1;
      r_rd_ptr    <= r_rd_ptr + 1'b1;
    end else if (src_ready) begin
      r_src_valid <= 1'b0;
    end
  end

  assign snk_ready         = r_snk_ready;
  assign src_valid         = r_src_valid;
  assign src_data          = r_src.dat;
  assign src_startofpacket = r_src.sop;
  assign src_endofpacket   = r_src.eop;
  assign src_empty         = r_src.emp;
  assign src_channel       = r_src.ch;

`ifdef AVST_PKT_FIFO_STATS_EN
  logic       w_fwd, w_orphan;
  logic [1:0] w_drops;

  assign w_fwd    = w_write && snk_endofpacket;
  assign w_orphan = w_acc && !snk_startofpacket && (r_state == S_IDLE);
  // A restart that also overflows counts both the abandoned and the refused packet.
  assign w_drops  = {1'b0, w_restart} + {1'b0, w_sop_ovf} + {1'b0, w_beat_ovf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_pkts     <= '0;
      stat_drop_pkts    <= '0;
      stat_orphan_beats <= '0;
    end else begin
      if (w_fwd) stat_fwd_pkts <= stat_fwd_pkts + 32'd1;
      stat_drop_pkts <= stat_drop_pkts + 32'(w_drops);
      if (w_orphan) stat_orphan_beats <= stat_orphan_beats + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Bench for avalon_st_pkt_fifo: directed packets plus random traffic; expected beats queued at issue, popped by a monitor.
// Stat counters are checked only when AVST_PKT_FIFO_STATS_EN is defined.
module tb_avalon_st_pkt_fifo;
  localparam int AW   = 4;
  localparam int MAXW = 12;
  localparam int CAP  = 15;

  typedef struct packed {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
    logic [0:0]  ch;
  } beat_t;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0, snk_startofpacket = 1'b0, snk_endofpacket = 1'b0;
  logic [1:0]  snk_empty = '0;
  logic [0:0]  snk_channel = '0;
  logic        snk_ready;
  logic [31:0] src_data;
  logic        src_valid, src_startofpacket, src_endofpacket;
  logic [1:0]  src_empty;
  logic [0:0]  src_channel;
  logic        src_ready = 1'b1;
`ifdef AVST_PKT_FIFO_STATS_EN
  logic [31:0] stat_fwd_pkts, stat_drop_pkts, stat_orphan_beats;
  int          s_fwd0, s_drop0, s_orph0;
`endif

  avalon_st_pkt_fifo #(
    .DATA_WIDTH(32), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(2), .ADDR_WIDTH(AW), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_startofpacket(snk_startofpacket),
    .snk_endofpacket(snk_endofpacket), .snk_empty(snk_empty), .snk_channel(snk_channel),
    .snk_ready(snk_ready),
    .src_data(src_data), .src_valid(src_valid), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket), .src_empty(src_empty), .src_channel(src_channel),
    .src_ready(src_ready)
`ifdef AVST_PKT_FIFO_STATS_EN
    , .stat_fwd_pkts(stat_fwd_pkts), .stat_drop_pkts(stat_drop_pkts),
    .stat_orphan_beats(stat_orphan_beats)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0, failures = 0;
  beat_t exp_q[$];
  int    rx_beats = 0;
  int    rdy_mode = 0;
  int    pat_idx = 0;
  logic [3:0] pat_bits = 4'b1001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready patterns: 0 always high, 1 random, 2 held low, 3 repeating 1,0,0,1.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: src_ready = 1'b1;
      1: src_ready = ($urandom_range(0, 2) != 0);
      2: src_ready = 1'b0;
      default: begin
        src_ready = pat_bits[3 - (pat_idx % 4)];
        pat_idx++;
      end
    endcase
  end

  beat_t held;
  bit    held_vld = 0;
  always @(negedge clk) begin
    beat_t act;
    act.dat = src_data;
    act.sop = src_startofpacket;
    act.eop = src_endofpacket;
    act.emp = src_empty;
    act.ch  = src_channel;
    if (!rst_n) begin
      held_vld = 0;
    end else begin
      if (held_vld) chk("hold_stable", 64'({src_valid, act}), 64'({1'b1, held}));
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", act);
        end else begin
          chk("beat", 64'(act), 64'(exp_q.pop_front()));
          rx_beats++;
        end
        held_vld = 0;
      end else if (src_valid) begin
        held     = act;
        held_vld = 1;
      end else begin
        held_vld = 0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    snk_valid = 1'b0;
    repeat (n) sync();
  endtask

  task automatic drive(input logic [31:0] d, input logic sop, input logic eop,
                       input logic [1:0] e, input logic [0:0] c);
    snk_valid = 1'b1; snk_data = d; snk_startofpacket = sop;
    snk_endofpacket = eop; snk_empty = e; snk_channel = c;
    sync();
    snk_valid = 1'b0;
  endtask

  // Good packets come out with sop/eop framing, the sop channel on every beat, empty only on eop.
  task automatic send_pkt(input int len, input logic [0:0] ch, input bit good,
                          input bit gaps, input bit term);
    for (int i = 0; i < len; i++) begin
      logic [31:0] d = $urandom;
      logic [1:0]  e = 2'($urandom);
      logic [0:0]  c = (i == 0) ? ch : 1'($urandom);
      logic        eop = term && (i == len - 1);
      if (good) exp_q.push_back('{dat: d, sop: (i == 0), eop: eop, emp: (eop ? e : 2'd0), ch: ch});
      drive(d, (i == 0), eop, e, c);
      if (gaps && !eop && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic wait_space(input int n);
    int k = 0;
    while (exp_q.size() + n > CAP && k < 3000) begin
      sync();
      k++;
    end
    chk("space_wait", 64'(exp_q.size() + n <= CAP), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      sync();
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

`ifdef AVST_PKT_FIFO_STATS_EN
  task automatic snap();
    s_fwd0 = int'(stat_fwd_pkts); s_drop0 = int'(stat_drop_pkts); s_orph0 = int'(stat_orphan_beats);
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, seen;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 64'({snk_ready, src_valid, src_startofpacket, src_endofpacket,
                              src_data, src_empty, src_channel}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("snk_ready_before_edge", 64'(snk_ready), 64'd0);
    sync();
    chk("snk_ready_after_edge", 64'(snk_ready), 64'd1);

    // Basic 3-beat packet with latency check.
    exp_q.push_back('{dat: 32'h11, sop: 1'b1, eop: 1'b0, emp: 2'd0, ch: 1'b1});
    exp_q.push_back('{dat: 32'h22, sop: 1'b0, eop: 1'b0, emp: 2'd0, ch: 1'b1});
    exp_q.push_back('{dat: 32'h33, sop: 1'b0, eop: 1'b1, emp: 2'd2, ch: 1'b1});
    drive(32'h11, 1'b1, 1'b0, 2'd3, 1'b1);
    drive(32'h22, 1'b0, 1'b0, 2'd1, 1'b0);
    drive(32'h33, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    chk("latency_edge_k", 64'(src_valid), 64'd0);
    @(negedge clk);
    chk("latency_edge_k1", 64'(src_valid), 64'd1);
    sync();
    wait_drain("basic_drain");

    exp_q.push_back('{dat: 32'hA5, sop: 1'b1, eop: 1'b1, emp: 2'd1, ch: 1'b0});
    drive(32'hA5, 1'b1, 1'b1, 2'd1, 1'b0);
    wait_drain("single_drain");

    rdy_mode = 3; pat_idx = 0;
    send_pkt(4, 1'b1, 1, 0, 1);
    wait_drain("backpressure_drain");
    rdy_mode = 0;

    // Overflow: 10 + 10 beats into 15 entries with the source stalled.
`ifdef AVST_PKT_FIFO_STATS_EN
    snap();
`endif
    rdy_mode = 2; idle(2);
    rx0 = rx_beats;
    send_pkt(10, 1'b0, 1, 0, 1);
    idle(2);
    send_pkt(10, 1'b1, 0, 0, 1);
    idle(3);
`ifdef AVST_PKT_FIFO_STATS_EN
    chk("ovf_drop_stat", 64'(int'(stat_drop_pkts) - s_drop0), 64'd1);
`endif
    rdy_mode = 0;
    wait_drain("ovf_drain");
    chk("ovf_beats", 64'(rx_beats - rx0), 64'd10);

    // Oversize around the MAXW boundary.
    wait_space(MAXW); send_pkt(MAXW + 1, 1'b0, 0, 0, 1);
    wait_space(MAXW); send_pkt(MAXW, 1'b1, 1, 0, 1);
    wait_space(MAXW); send_pkt(MAXW + 3, 1'b0, 0, 0, 1);
    wait_space(2);    send_pkt(2, 1'b1, 1, 0, 1);
    wait_drain("oversize_drain");

    // Protocol errors: two orphans, then a second sop at beat 3.
`ifdef AVST_PKT_FIFO_STATS_EN
    snap();
`endif
    drive($urandom, 1'b0, 1'b0, 2'd0, 1'b0);
    drive($urandom, 1'b0, 1'b0, 2'd0, 1'b1);
    send_pkt(2, 1'b0, 0, 0, 0);
    send_pkt(4, 1'b1, 1, 0, 1);
    wait_drain("protocol_drain");
`ifdef AVST_PKT_FIFO_STATS_EN
    chk("orphan_stat", 64'(int'(stat_orphan_beats) - s_orph0), 64'd2);
    chk("restart_drop_stat", 64'(int'(stat_drop_pkts) - s_drop0), 64'd1);
    chk("protocol_fwd_stat", 64'(int'(stat_fwd_pkts) - s_fwd0), 64'd1);
`endif

    // Reset with committed and partial data in flight.
    rdy_mode = 2; idle(2);
    send_pkt(3, 1'b0, 1, 0, 1);
    send_pkt(5, 1'b1, 1, 0, 1);
    send_pkt(2, 1'b0, 0, 0, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({snk_ready, src_valid, src_startofpacket, src_endofpacket,
                               src_data, src_empty, src_channel}), 64'd0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    rdy_mode = 0;
    seen = 0;
    repeat (6) begin
      sync();
      if (src_valid) seen++;
    end
    chk("post_rst_empty", 64'(seen), 64'd0);
    send_pkt(3, 1'b1, 1, 0, 1);
    wait_drain("post_rst_drain");

    // Random traffic with random downstream ready.
    rdy_mode = 1;
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 3);
      int len  = $urandom_range(1, MAXW);
      int n    = $urandom_range(1, 6);
      logic [0:0] ch = 1'($urandom);
      case (kind)
        0: begin wait_space(len); send_pkt(len, ch, 1, 1, 1); end
        1: begin wait_space(MAXW); send_pkt($urandom_range(MAXW + 1, MAXW + 4), ch, 0, 1, 1); end
        2: for (int j = 0; j < n % 4 + 1; j++) drive($urandom, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom));
        default: begin
          wait_space(MAXW);
          send_pkt(n, ch, 0, 1, 0);
          send_pkt(len, ~ch, 1, 1, 1);
        end
      endcase
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    wait_drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
